// File: rtl/fpmul_issue.sv
// fpmul_issue: issue stage around an external combinational FP32 multiplier.
// Operands are captured in IDLE, special cases and exponent range are resolved
// in EXEC, and the result is queued in a 2-entry output FIFO.
module fpmul_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        in_ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_s,
  output logic        out_valid,
  output logic [31:0] out_s,
  output logic [2:0]  out_flags,
  input  logic        out_ready
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EXEC = 1'b1;

  logic        state;
  logic        state_next;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic [34:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [1:0]  count_next;

  logic        accept;
  logic        push;
  logic        pop;

  logic [7:0]  ea;
  logic [7:0]  eb;
  logic        a_nan;
  logic        b_nan;
  logic        a_inf;
  logic        b_inf;
  logic        a_zero;
  logic        b_zero;
  logic        sign;
  logic [8:0]  exp_sum;
  logic        ovf;
  logic        unf;
  logic [31:0] res_s;
  logic [2:0]  res_flags;
  logic [34:0] head;

  // in_ready is forced low while reset is asserted, not just after it.
  assign in_ready = !rst && (state == ST_IDLE) && (count < 2'd2);
  assign accept   = in_valid && in_ready;
  assign push     = (state == ST_EXEC);
  assign pop      = out_valid && out_ready;

  assign mul_a = op_a;
  assign mul_b = op_b;

  // Operand classification; denormals count as zero.
  assign ea      = op_a[30:23];
  assign eb      = op_b[30:23];
  assign a_nan   = (ea == 8'hFF) && (op_a[22:0] != 23'h0);
  assign b_nan   = (eb == 8'hFF) && (op_b[22:0] != 23'h0);
  assign a_inf   = (ea == 8'hFF) && (op_a[22:0] == 23'h0);
  assign b_inf   = (eb == 8'hFF) && (op_b[22:0] == 23'h0);
  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);
  assign sign    = op_a[31] ^ op_b[31];
  assign exp_sum = {1'b0, ea} + {1'b0, eb};

  // Biased sum 381/127 are the borderline cases where the multiplier's
  // normalisation carry decides whether the exponent is still in range.
  assign ovf = (exp_sum >= 9'd382) || ((exp_sum == 9'd381) && (mul_s[30:23] == 8'hFF));
  assign unf = (exp_sum <= 9'd126) || ((exp_sum == 9'd127) && (mul_s[30:23] == 8'h00));

  // Result selection in priority order: invalid, infinity, zero, range, normal.
  always_comb begin
    res_s     = 32'h0;
    res_flags = 3'b000;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      res_s     = 32'h7FC0_0000;
      res_flags = 3'b100;
    end else if (a_inf || b_inf) begin
      res_s = {sign, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      res_s = {sign, 31'h0};
    end else if (ovf) begin
      res_s     = {sign, 8'hFF, 23'h0};
      res_flags = 3'b010;
    end else if (unf) begin
      res_s     = {sign, 31'h0};
      res_flags = 3'b001;
    end else begin
      res_s = {sign, mul_s[30:0]};
    end
  end

  // Two-state issue FSM: EXEC always lasts exactly one cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state and operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      op_a  <= 32'h0;
      op_b  <= 32'h0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_a <= in_a;
        op_b <= in_b;
      end
    end
  end

  // FIFO occupancy: push and pop together leave it unchanged.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end
  end

  // FIFO pointers and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // FIFO storage; never reset, the output is gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {res_s, res_flags};
    end
  end

  assign out_valid = (count != 2'd0);
  assign head      = out_valid ? fifo_mem[rd_ptr] : 35'h0;
  assign out_s     = head[34:3];
  assign out_flags = head[2:0];

endmodule

// File: doc/fpmul_issue.md
FPMUL_ISSUE -- requirements
Module: fpmul_issue

Interface
REQ-001 The module SHALL have these ports, in this order:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  an operand pair is offered.
- in_a  input  32  IEEE-754 single operand A.
- in_b  input  32  IEEE-754 single operand B.
- in_ready  output  1  the block accepts the operand pair.
- mul_a  output  32  operand A driven to the downstream combinational multiplier.
- mul_b  output  32  operand B driven to the downstream combinational multiplier.
- mul_s  input  32  product returned by the multiplier (normal operands only).
- out_valid  output  1  a result is available.
- out_s  output  32  final product.
- out_flags  output  3  {invalid, overflow, underflow}.
- out_ready  input  1  the consumer takes the result.
REQ-002 The block SHALL use one clock (clk); reset (rst) SHALL be asynchronous and active-high.

Function
REQ-003 The FSM SHALL have two states: IDLE and EXEC.
REQ-004 in_ready SHALL be 1 only when the state is IDLE and the output FIFO count is less than 2.
REQ-005 On in_valid && in_ready, the block SHALL register in_a and in_b into the operand registers and enter EXEC.
REQ-006 mul_a and mul_b SHALL be driven continuously from the operand registers.
REQ-007 In EXEC, the block SHALL compute the result and flags from the operand registers and mul_s, push them into the FIFO at the end of that cycle, and return to IDLE.
REQ-008 Latency: a pair accepted at edge N SHALL produce out_valid at edge N+2 when the FIFO is empty.
REQ-009 Throughput SHALL be at most 1 result per 2 cycles.
REQ-010 Operand classification, with exponent e and mantissa m:
- NaN: e=255, m≠0.
- Inf: e=255, m=0.
- Zero: e=0, any m (denormals flush to zero).
- Otherwise: Normal.
REQ-011 The result sign SHALL be in_a[31] XOR in_b[31] in all cases except NaN.
REQ-012 If either operand is NaN, or one is Inf and the other Zero, out_s SHALL be 32'h7FC00000 with invalid=1.
REQ-013 Otherwise, if either operand is Inf, out_s SHALL be {sign, 8'hFF, 23'h0} with all flags 0.
REQ-014 Otherwise, if either operand is Zero, out_s SHALL be {sign, 31'h0} with all flags 0.
REQ-015 Both Normal: let S = ea + eb as a 9-bit unsigned sum.
REQ-016 Overflow SHALL be detected when S ≥ 382, or when S = 381 and mul_s[30:23] = 8'hFF; then out_s = {sign, 8'hFF, 23'h0} and overflow=1.
REQ-017 Underflow SHALL be detected when S ≤ 126, or when S = 127 and mul_s[30:23] = 0; then out_s = {sign, 31'h0} and underflow=1.
REQ-018 Otherwise, out_s SHALL be {sign, mul_s[30:0]} with all flags 0.
REQ-019 The output FIFO SHALL hold 2 entries of 35 bits each (32-bit result plus 3 flags).
REQ-020 The FIFO SHALL use a 1-bit write pointer, a 1-bit read pointer and a 2-bit count; both pointers wrap modulo 2.
REQ-021 out_valid SHALL equal (count ≠ 0); out_s and out_flags SHALL present the head entry.
REQ-022 A pop SHALL occur on out_valid && out_ready.
REQ-023 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-024 A push into a full FIFO SHALL be impossible by construction (see REQ-004).
REQ-025 out_s and out_flags SHALL hold stable while out_valid && !out_ready.
REQ-026 in_a and in_b SHALL be ignored whenever in_ready is 0.

Reset
REQ-027 While rst is high, the block SHALL hold: state IDLE, operand registers 0, mul_a = mul_b = 0, FIFO count 0, both FIFO pointers 0, out_valid 0, in_ready 0.
REQ-028 After rst is released, in_ready SHALL be 1.
REQ-029 FIFO storage contents need not be reset, but out_s and out_flags SHALL read 0 while count = 0.
REQ-030 Reset asserted during EXEC SHALL discard the in-flight operation; no result SHALL appear after reset is released.

Verification
REQ-031 The bench SHALL cover 2.0 × 3.0: in_a = 40000000, in_b = 40400000, accepted at edge N -> out_s = 40C00000, flags 000, out_valid at N+2.
REQ-032 The bench SHALL cover invalid operations: 7F800000 × 00000000 -> 7FC00000, flags 100; 7FC00001 × 3F800000 -> 7FC00000, flags 100.
REQ-033 The bench SHALL cover overflow and underflow: 7F000000 × 7F000000 -> 7F800000, flags 010; 00800000 × 80800000 -> 80000000, flags 001.
REQ-034 The bench SHALL cover backpressure: out_ready held 0, three pairs offered -> two accepted, in_ready held 0; then out_ready = 1 -> results emerge in issue order, and the third pair is accepted once count < 2.
REQ-035 The bench SHALL cover reset mid-operation: rst pulsed during EXEC -> out_valid stays 0, count is 0 after release, and the next issued pair completes normally.
REQ-036 The bench SHALL cover simultaneous push and pop: count = 1 with out_ready = 1 on the EXEC cycle -> count stays 1 and out_s advances to the new result.
